// File: rtl/enc_1_act.sv
// enc_1_act: activation stage behind the 6-output encoder dense layer.
// Captures a packed N-element signed fixed-point vector, applies the activation
// one element per clock, and presents the activated vector with valid/ready.
// Build option: define HARD_SIGMOID_EN to select hard sigmoid instead of ReLU.
module enc_1_act #(
   parameter int BITSIZE = 16,
   parameter int FRAC    = 8,
   parameter int N       = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BITSIZE*N-1:0] x,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BITSIZE*N-1:0] y,
   output logic                 busy
);

   // Two guard bits keep the shifted/offset value exact before clamping.
   localparam int WIDE_W = BITSIZE + 2;
   localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

`ifdef HARD_SIGMOID_EN
   // 1.0 and 0.5 in the element's fixed-point format.
   localparam logic signed [WIDE_W-1:0] C_ONE  = WIDE_W'(1 << FRAC);
   localparam logic signed [WIDE_W-1:0] C_HALF = WIDE_W'(1 << (FRAC - 1));
`else
   // Largest positive element value; ReLU never exceeds it but the clamp is explicit.
   localparam logic signed [WIDE_W-1:0] C_MAX_POS = WIDE_W'((1 << (BITSIZE - 1)) - 1);
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Captured input vector, and the output vector built up element by element.
   logic signed [BITSIZE-1:0] r_buf [N];
   logic signed [BITSIZE-1:0] r_y   [N];
   logic [IDX_W-1:0]          r_idx;

   logic                      w_accept;
   logic                      w_last;
   logic signed [BITSIZE-1:0] w_elem;
   logic signed [WIDE_W-1:0]  w_wide;
   logic signed [WIDE_W-1:0]  w_pre;
   logic signed [WIDE_W-1:0]  w_clamped;
   logic signed [BITSIZE-1:0] w_act;

   // A vector is taken only while idle; in_valid in RUN/DONE is simply ignored.
   assign w_accept = (r_state == ST_IDLE) && in_valid;
   assign w_last   = (r_idx == LAST_IDX);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values; blocking here would create order-dependent races.
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Element-wise activation of the current element, computed on the widened value.
   always_comb begin
      w_elem = r_buf[r_idx];
      w_wide = {{2{w_elem[BITSIZE-1]}}, w_elem};
`ifdef HARD_SIGMOID_EN
      // Arithmetic shift keeps the sign; clamp to [0, 1.0].
      w_pre = (w_wide >>> 2) + C_HALF;
      if (w_pre[WIDE_W-1]) begin
         w_clamped = '0;
      end else if (w_pre > C_ONE) begin
         w_clamped = C_ONE;
      end else begin
         w_clamped = w_pre;
      end
`else
      // ReLU: negatives go to zero, positives pass through.
      w_pre = w_wide;
      if (w_pre[WIDE_W-1]) begin
         w_clamped = '0;
      end else if (w_pre > C_MAX_POS) begin
         w_clamped = C_MAX_POS;
      end else begin
         w_clamped = w_pre;
      end
`endif
      w_act = w_clamped[BITSIZE-1:0];
   end

   // Capture on accept, then write one activated element per RUN cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx <= '0;
         // NOTE: the buffers are small register arrays that must read as zero
         // after reset, so they are cleared here rather than left uninitialised.
         for (int k = 0; k < N; k++) begin
            r_buf[k] <= '0;
            r_y[k]   <= '0;
         end
      end else begin
         if (w_accept) begin
            r_idx <= '0;
            for (int k = 0; k < N; k++) begin
               r_buf[k] <= x[BITSIZE*k +: BITSIZE];
            end
         end else if (r_state == ST_RUN) begin
            r_y[r_idx] <= w_act;
            r_idx      <= w_last ? '0 : r_idx + IDX_W'(1);
         end
      end
   end

   // Repack the output elements in the same order as x.
   for (genvar g = 0; g < N; g++) begin : g_pack_y
      assign y[BITSIZE*g +: BITSIZE] = r_y[g];
   end

endmodule

// File: tb/tb_enc_1_act.sv
// Directed bench for enc_1_act: reset state, activation values, latency,
// backpressure, back-to-back vectors, mid-run reset and input change after capture.
module tb_enc_1_act;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [95:0] x;
   logic        out_valid;
   logic        out_ready;
   logic [95:0] y;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int n;

   // Vectors written element 5 first down to element 0.
   localparam logic [95:0] V1 = {16'h0001, 16'h8000, 16'h7FFF, 16'h0000, 16'hFF00, 16'h0180};
   localparam logic [95:0] V2 = {16'h8000, 16'hFC00, 16'h0400, 16'h0200, 16'h0100, 16'h0000};
`ifdef HARD_SIGMOID_EN
   localparam logic [95:0] E1 = {16'h0080, 16'h0000, 16'h0100, 16'h0080, 16'h0040, 16'h00E0};
   localparam logic [95:0] E2 = {16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h00C0, 16'h0080};
`else
   localparam logic [95:0] E1 = {16'h0001, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0180};
   localparam logic [95:0] E2 = {16'h0000, 16'h0000, 16'h0400, 16'h0200, 16'h0100, 16'h0000};
`endif

   enc_1_act dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Count edges until out_valid; bounded so a stuck DUT still ends the run.
   task automatic wait_out(output int cnt);
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 40) begin
         step();
         cnt++;
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x         = '0;
      #3;
      check("rst_in_ready",  96'(in_ready),  96'(1'b1));
      check("rst_out_valid", 96'(out_valid), 96'(1'b0));
      check("rst_busy",      96'(busy),      96'(1'b0));
      check("rst_y",         y,              96'h0);
      step();
      step();
      reset = 1'b0;
      step();

      // ReLU/activation vector, latency, and x changing right after capture.
      x        = V1;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      x        = 96'hDEAD_BEEF_1234_5678_9ABC_DEF0;
      check("t1_busy",     96'(busy),     96'(1'b1));
      check("t1_in_ready", 96'(in_ready), 96'(1'b0));
      wait_out(n);
      check("t1_latency",  96'(n), 96'(6));
      check("t1_y",        y, E1);
      check("t1_done_rdy", 96'(in_ready), 96'(1'b0));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("t1_ov_low",   96'(out_valid), 96'(1'b0));
      check("t1_idle_rdy", 96'(in_ready),  96'(1'b1));
      check("t1_idle_bsy", 96'(busy),      96'(1'b0));

      // Second vector with in_valid asserted during RUN, then backpressure in DONE.
      x        = V2;
      in_valid = 1'b1;
      step();
      x = V1;
      step();
      step();
      in_valid = 1'b0;
      wait_out(n);
      check("t3_latency", 96'(n), 96'(4));
      check("t3_y",       y, E2);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i == 3);
         step();
         check("bp_out_valid", 96'(out_valid), 96'(1'b1));
         check("bp_y",         y, E2);
         check("bp_in_ready",  96'(in_ready), 96'(1'b0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("t3_idle_rdy", 96'(in_ready), 96'(1'b1));
      step();
      step();
      check("t3_no_capture", 96'(busy), 96'(1'b0));
      check("t3_y_held",     y, E2);

      // Back-to-back with out_ready and in_valid held high.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      x         = V2;
      step();
      x = V1;
      check("b2b_a_busy", 96'(busy), 96'(1'b1));
      wait_out(n);
      check("b2b_a_lat", 96'(n), 96'(6));
      check("b2b_a_y",   y, E2);
      step();
      check("b2b_idle_rdy", 96'(in_ready),  96'(1'b1));
      check("b2b_idle_ov",  96'(out_valid), 96'(1'b0));
      step();
      in_valid = 1'b0;
      check("b2b_b_busy", 96'(busy), 96'(1'b1));
      wait_out(n);
      check("b2b_b_lat", 96'(n), 96'(6));
      check("b2b_b_y",   y, E1);
      step();
      check("b2b_end_rdy", 96'(in_ready), 96'(1'b1));
      step();
      check("b2b_once", 96'(busy), 96'(1'b0));
      out_ready = 1'b0;

      // Reset just before the third RUN edge discards the partial vector.
      x        = V1;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      reset = 1'b1;
      #1;
      check("mid_rst_y",     y,               96'h0);
      check("mid_rst_ov",    96'(out_valid),  96'(1'b0));
      check("mid_rst_rdy",   96'(in_ready),   96'(1'b1));
      check("mid_rst_busy",  96'(busy),       96'(1'b0));
      step();
      reset = 1'b0;
      step();
      x        = V2;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_out(n);
      check("post_rst_lat", 96'(n), 96'(6));
      check("post_rst_y",   y, E2);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("post_rst_rdy", 96'(in_ready), 96'(1'b1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
